// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : CPU-priority arbiter for a single-port sync-read data memory, with
//           a starvation-bounded auxiliary port and registered aux read return.
// Rev     : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU MEM-stage port
  input  logic              i_cpu_re,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  // auxiliary port
  input  logic              i_aux_req,
  input  logic              i_aux_we,
  input  logic [ADDR_W-1:0] i_aux_addr,
  input  logic [DATA_W-1:0] i_aux_wdata,
  output logic              o_aux_gnt,
  output logic              o_aux_rvalid,
  output logic [DATA_W-1:0] o_aux_rdata,
  // memory port
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  localparam logic [1:0] c_OWN_NONE = 2'd0;
  localparam logic [1:0] c_OWN_CPU  = 2'd1;
  localparam logic [1:0] c_OWN_AUX  = 2'd2;

  logic [3:0] r_starve;
  logic [1:0] r_rd_own;
  logic [1:0] w_rd_own_nxt;
  logic       w_cpu_act;
  logic       w_aux_gnt;
  logic       w_aux_rd_issue;
  logic       w_cpu_rd_issue;
  logic       w_load_aux;
  logic              r_aux_rvalid;
  logic [DATA_W-1:0] r_aux_rdata;

  assign w_cpu_act = i_cpu_re | i_cpu_we;
  assign w_aux_gnt = i_aux_req & (~w_cpu_act | (r_starve == c_STARVE_MAX));

  // A granted aux slot pre-empts the CPU, so only one read can be issued per cycle.
  assign w_aux_rd_issue = w_aux_gnt & ~i_aux_we;
  assign w_cpu_rd_issue = w_cpu_act & ~w_aux_gnt & ~i_cpu_we;

  assign o_aux_gnt    = w_aux_gnt;
  assign o_cpu_stall  = w_cpu_act & w_aux_gnt;
  assign o_cpu_rdata  = i_mem_rdata;
  assign o_aux_rvalid = r_aux_rvalid;
  assign o_aux_rdata  = r_aux_rdata;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_aux_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_aux_we;
      o_mem_addr  = i_aux_addr;
      o_mem_wdata = i_aux_wdata;
    end else if (w_cpu_act) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (w_aux_gnt || !i_aux_req) begin
      r_starve <= 4'd0;
    end else if (r_starve != c_STARVE_MAX) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Read-return owner: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_own <= c_OWN_NONE;
    end else begin
      r_rd_own <= w_rd_own_nxt;
    end
  end

  // Read-return owner: next state comes only from this cycle's issued read
  always_comb begin
    w_rd_own_nxt = c_OWN_NONE;
    if (w_aux_rd_issue) begin
      w_rd_own_nxt = c_OWN_AUX;
    end else if (w_cpu_rd_issue) begin
      w_rd_own_nxt = c_OWN_CPU;
    end
  end

  // Read-return owner: outputs
  always_comb begin
    w_load_aux = 1'b0;
    if (r_rd_own == c_OWN_AUX) begin
      w_load_aux = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aux_rvalid <= 1'b0;
      r_aux_rdata  <= '0;
    end else begin
      r_aux_rvalid <= w_load_aux;
      if (w_load_aux) begin
        r_aux_rdata <= i_mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Scoreboard bench for dmem_arbiter with a sync-read memory stub.
// Rev     : 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_cpu_re = 1'b0, i_cpu_we = 1'b0;
  logic [ADDR_W-1:0] i_cpu_addr = '0;
  logic [DATA_W-1:0] i_cpu_wdata = '0;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_stall;
  logic              i_aux_req = 1'b0, i_aux_we = 1'b0;
  logic [ADDR_W-1:0] i_aux_addr = '0;
  logic [DATA_W-1:0] i_aux_wdata = '0;
  logic              o_aux_gnt, o_aux_rvalid;
  logic [DATA_W-1:0] o_aux_rdata;
  logic              o_mem_en, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata = '0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_re(i_cpu_re), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_rdata(o_cpu_rdata), .o_cpu_stall(o_cpu_stall),
    .i_aux_req(i_aux_req), .i_aux_we(i_aux_we), .i_aux_addr(i_aux_addr),
    .i_aux_wdata(i_aux_wdata), .o_aux_gnt(o_aux_gnt), .o_aux_rvalid(o_aux_rvalid),
    .o_aux_rdata(o_aux_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory stub (device behind the arbiter) and the bench's own view of its contents
  logic [DATA_W-1:0] stub_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem  [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) stub_mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata <= stub_mem[o_mem_addr];
    end
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t aux_q[$];
  exp_t cpu_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int waited = 0;
  logic last_gnt = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: CPU wins unless aux has already waited STARVE_MAX requesting cycles.
  task automatic model_step();
    logic cact, eg;
    exp_t e;
    cact = i_cpu_re | i_cpu_we;
    if (!rst_n) waited = 0;
    eg = i_aux_req && (!cact || waited == STARVE_MAX);
    chk("aux_gnt", o_aux_gnt, eg);
    chk("cpu_stall", o_cpu_stall, cact && eg);
    chk("mem_en", o_mem_en, eg || cact);
    if (eg) begin
      chk("mem_we_aux", o_mem_we, i_aux_we);
      chk("mem_addr_aux", o_mem_addr, i_aux_addr);
    end else if (cact) begin
      chk("mem_we_cpu", o_mem_we, i_cpu_we);
      chk("mem_addr_cpu", o_mem_addr, i_cpu_addr);
    end
    if (!rst_n) begin
      aux_q.delete();
      cpu_q.delete();
    end
    if (eg) begin
      if (i_aux_we) ref_mem[i_aux_addr] = i_aux_wdata;
      else if (rst_n) begin
        e.data = ref_mem[i_aux_addr]; e.due = cyc + 2; aux_q.push_back(e);
      end
    end else if (cact) begin
      if (i_cpu_we) ref_mem[i_cpu_addr] = i_cpu_wdata;
      else if (rst_n) begin
        e.data = ref_mem[i_cpu_addr]; e.due = cyc + 1; cpu_q.push_back(e);
      end
    end
    if (rst_n && i_aux_req && !eg) waited = (waited < STARVE_MAX) ? waited + 1 : waited;
    else waited = 0;
    last_gnt = eg;
  endtask

  task automatic cycle(input logic rst, input logic cre, input logic cwe,
                       input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                       input logic areq, input logic awe,
                       input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
    @(posedge clk);
    #1;
    rst_n = rst;
    i_cpu_re = cre; i_cpu_we = cwe; i_cpu_addr = ca; i_cpu_wdata = cd;
    i_aux_req = areq; i_aux_we = awe; i_aux_addr = aa; i_aux_wdata = ad;
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: pops expected read returns as the DUT presents them
  always @(negedge clk) begin
    exp_t e;
    if (o_aux_rvalid) begin
      if (aux_q.size() == 0) begin
        chk("aux_rvalid_spurious", o_aux_rvalid, 1'b0);
      end else begin
        e = aux_q.pop_front();
        chk("aux_rdata", o_aux_rdata, e.data);
        chk("aux_rvalid_cycle", cyc, e.due);
      end
    end else if (aux_q.size() > 0 && aux_q[0].due <= cyc) begin
      e = aux_q.pop_front();
      chk("aux_rvalid_missing", o_aux_rvalid, 1'b1);
    end
    if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
      e = cpu_q.pop_front();
      chk("cpu_rdata", o_cpu_rdata, e.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int gi;
    logic               pend, p_we;
    logic [ADDR_W-1:0]  p_addr;
    logic [DATA_W-1:0]  p_data;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      stub_mem[i] = 32'h0101_0101 * i;
      ref_mem[i]  = 32'h0101_0101 * i;
    end

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("rst_aux_rvalid", o_aux_rvalid, 1'b0);
    chk("rst_aux_rdata", o_aux_rdata, 32'h0);
    idle(2);

    // Idle aux write then aux read of the same word
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd3, '0);
    idle(3);
    chk("aux_rdata_hold", o_aux_rdata, 32'hDEADBEEF);

    // Starvation: continuous CPU reads, aux raised at cycle 0
    gi = -1;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 5'(i), '0, (gi < 0), 1'b0, 5'd3, '0);
      if (o_aux_gnt) gi = i;
    end
    chk("starve_gnt_cycle", gi, 4);
    idle(2);

    // CPU write then CPU read of the same word
    cycle(1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 1'b0, 5'd7, '0, 1'b0, 1'b0, '0, '0);
    idle(1);

    // Ordering: CPU write in T, forced aux read of the same word in T+1
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd1, '0);
    cycle(1'b1, 1'b0, 1'b1, 5'd1, 32'hA5, 1'b1, 1'b0, 5'd1, '0);
    cycle(1'b1, 1'b1, 1'b0, 5'd2, '0, 1'b1, 1'b0, 5'd1, '0);
    idle(3);
    chk("order_aux_rdata", o_aux_rdata, 32'hA5);

    // Aux withdraw under CPU traffic, then a fresh request must wait the full bound
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 5'd4, '0, 1'b1, 1'b0, 5'd9, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 5'd4, '0, 1'b0, 1'b0, '0, '0);
    gi = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 5'd5, '0, (gi < 0), 1'b0, 5'd9, '0);
      if (o_aux_gnt) gi = i;
    end
    chk("withdraw_gnt_cycle", gi, 4);
    idle(2);

    // Reset with an aux read in flight
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd3, '0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("midrst_aux_rvalid", o_aux_rvalid, 1'b0);
    chk("midrst_aux_rdata", o_aux_rdata, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    idle(3);
    chk("post_rst_mem_en", o_mem_en, 1'b0);

    // Randomized traffic
    pend = 1'b0; p_we = 1'b0; p_addr = '0; p_data = '0;
    for (int i = 0; i < 400; i++) begin
      logic cre, cwe;
      int r;
      r = $urandom_range(0, 9);
      cre = (r < 4) || (r == 8);
      cwe = (r >= 4 && r < 7) || (r == 8);
      if (pend) begin
        if ($urandom_range(0, 15) == 0) pend = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        pend = 1'b1; p_we = 1'($urandom); p_addr = 5'($urandom_range(0, 7));
        p_data = $urandom;
      end
      cycle(1'b1, cre, cwe, 5'($urandom_range(0, 7)), $urandom, pend, p_we, p_addr, p_data);
      if (last_gnt) pend = 1'b0;
    end
    idle(4);
    chk("aux_q_drained", aux_q.size(), 0);
    chk("cpu_q_drained", cpu_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-port 32x32 data memory behind the MEM pipeline stage. It shares the memory between the CPU MEM-stage port and an auxiliary port used by the switch/display/debug logic. The CPU has priority. A saturating starvation counter guarantees the auxiliary port one slot after a bounded wait, and the arbiter stalls the pipeline for that slot. The memory is synchronous-read: data appears one cycle after the enable.

## Interface
- ADDR_W, 5, word-address width (memory depth 2^ADDR_W)
- DATA_W, 32, data width
- STARVE_MAX, 4, cycles aux may wait before forced grant (1..15)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_re  in  1  MEM-stage read request (level, this cycle)
- cpu_we  in  1  MEM-stage write request (level, this cycle; wins over cpu_re if both set)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data; passthrough of mem_rdata
- cpu_stall  out  1  pipeline must hold MEM and earlier stages this cycle
- aux_req  in  1  aux request; held with aux_we/addr/wdata stable until aux_gnt
- aux_we  in  1  aux write (1) / read (0)
- aux_addr  in  ADDR_W  aux word address
- aux_wdata  in  DATA_W  aux write data
- aux_gnt  out  1  one-cycle grant; access is performed in this cycle
- aux_rvalid  out  1  one-cycle pulse, aux_rdata valid
- aux_rdata  out  DATA_W  registered aux read data, held until next aux read completes
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en && !mem_we

## Operation
- cpu_act = cpu_re | cpu_we. starve is a 4-bit saturating counter.
- aux_gnt = aux_req & (!cpu_act | starve == STARVE_MAX). This is combinational.
- cpu_stall = cpu_act & aux_gnt. A stalled CPU access is not performed. The CPU re-presents it next cycle and is served then, because starve is 0.
- Memory mux:
  - If aux_gnt: drive aux_we/aux_addr/aux_wdata and mem_en=1.
  - Else if cpu_act: drive cpu_we/cpu_addr/cpu_wdata and mem_en=1.
  - Else: mem_en=0, mem_we=0, and addr/wdata are 0.
- starve update per edge:
  - Cleared to 0 on aux_gnt or !aux_req.
  - Otherwise incremented, saturating at STARVE_MAX.
- Read-return tracking uses the registered owner rd_own ∈ {NONE, CPU, AUX}. It is set each edge from this cycle's read: aux_gnt & !aux_we gives AUX; a CPU read issued gives CPU; anything else gives NONE.
- When rd_own==AUX:
  - aux_rdata <= mem_rdata at the next edge.
  - aux_rvalid is registered and pulses in the cycle after the load.
- cpu_rdata = mem_rdata always. It is meaningful only in the cycle where rd_own==CPU.
- Writes complete in the grant cycle. There is no write response.
- The arbiter never reorders: a read issued in cycle T returns data reflecting all writes issued before T.

## Timing
- Reset (rst=0, asynchronous):
  - starve=0, rd_own=NONE, aux_rvalid=0, aux_rdata=0.
  - The combinational outputs follow their inputs. Reset does not force idle memory inputs.
- Reset mid-read: the in-flight return is discarded and no aux_rvalid is issued after release.
- CPU read: mem_en in cycle T, cpu_rdata valid in T+1.
- Aux read: grant in T, mem_rdata in T+1, aux_rdata loaded at the T+1→T+2 edge, aux_rvalid=1 in T+2.
- Aux worst-case wait under a continuous CPU stream: STARVE_MAX cycles of aux_req high before aux_gnt.
- Forced grant stalls the CPU for exactly one cycle. Back-to-back aux requests cannot each force a stall, because starve restarts at 0.
- Simultaneous aux_gnt read and a CPU request: the CPU is stalled, so there is no ownership conflict on mem_rdata.
- aux_req dropped before grant is legal. starve clears and nothing is issued.

## Test plan
- Reset: drive rst=0 mid-stream with an aux read in flight → aux_rvalid=0 and aux_rdata=0; after release with no requests, mem_en=0.
- Idle aux write: cpu idle, aux write addr 3 data 0xDEADBEEF → aux_gnt same cycle. Aux read addr 3 → aux_rvalid two cycles after gnt with aux_rdata=0xDEADBEEF.
- CPU priority / starvation with STARVE_MAX=4:
  - Stimulus: cpu_re held every cycle, aux_req raised at cycle 0.
  - aux_gnt and cpu_stall in cycle 4 only; no CPU memory access that cycle.
  - CPU is served again in cycle 5.
- CPU read return: CPU write addr 7 = 0x12345678, then CPU read addr 7 → cpu_rdata=0x12345678 one cycle after the read.
- Ordering: CPU write addr 1 = 0xA5 in T, forced aux read addr 1 in T+1 → aux_rdata=0xA5.
- Aux withdraw: aux_req high 2 cycles under CPU traffic, then low → no aux_gnt, starve back to 0, no stall.
